bomb_slots_fsm: RTL and testbench
=================================

BOMB_SLOTS_FSM -- requirements
Module: bomb_slots_fsm

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of independent bomb slots (1..16).
REQ-002 Parameter FUSE_FRAMES, default 90, frames from placement to detonation (>=1).
REQ-003 Parameter BLAST_FRAMES, default 30, frames a slot stays exploding (>=1).
REQ-004 Parameter OFF_X / OFF_Y, default 1000 / 1000, off-screen coordinate of an idle slot.
REQ-005 Parameter CHAIN_RANGE, default 64, chain-reaction reach in pixels.
REQ-006 clk  in  1  single system clock; all state changes on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-009 place_req  in  1  one-cycle request to drop a bomb.
REQ-010 place_x / place_y  in  11 each, signed  bomb top-left, sampled with place_req.
REQ-011 collision  in  NUM_SLOTS  per-slot early-detonation request.
REQ-012 place_ack / place_nack  out  1 each  registered placement result pulse.
REQ-013 place_slot  out  $clog2(NUM_SLOTS) (min 1)  slot index granted; valid with place_ack.
REQ-014 bomb_exist  out  NUM_SLOTS  slot ARMED.
REQ-015 bomb_exploded  out  NUM_SLOTS  slot EXPLODING.
REQ-016 explode_pulse  out  NUM_SLOTS  one-cycle pulse on entry to EXPLODING.
REQ-017 topLeftX_out / topLeftY_out  out  11*NUM_SLOTS, signed, packed, slot 0 in LSBs  slot position.
REQ-018 full  out  1  no slot IDLE (registered state).

Function
REQ-019 Each slot SHALL run its own FSM: IDLE -> ARMED -> EXPLODING -> IDLE, with a frame counter of width $clog2(max(FUSE_FRAMES,BLAST_FRAMES)+1).
REQ-020 On place_req with full=0, the lowest-index IDLE slot SHALL enter ARMED next cycle, latch place_x/place_y, clear its counter; place_ack and place_slot asserted that same next cycle.
REQ-021 On place_req with full=1, no state change; place_nack SHALL pulse one cycle later.
REQ-022 full SHALL reflect registered state; a slot leaving EXPLODING is allocatable only from the following cycle.
REQ-023 ARMED: counter increments on startOfFrame; when an increment reaches FUSE_FRAMES, slot enters EXPLODING with counter cleared.
REQ-024 ARMED with collision[i]=1 SHALL enter EXPLODING next cycle regardless of counter; collision wins over a simultaneous startOfFrame.
REQ-025 collision[i] in IDLE or EXPLODING SHALL be ignored.
REQ-026 EXPLODING: counter increments on startOfFrame; on reaching BLAST_FRAMES, slot returns to IDLE, position reset to OFF_X/OFF_Y.
REQ-027 explode_pulse[i] SHALL be high exactly in the first cycle bomb_exploded[i] is high.
REQ-028 bomb_exist and bomb_exploded SHALL never both be high for one slot.
REQ-029 Outputs SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-030 While reset=1, all slots IDLE, counters 0, positions OFF_X/OFF_Y, all outputs 0 except topLeft outputs; effect immediate, independent of clk.
REQ-031 Reset mid-fuse or mid-blast SHALL discard the bomb with no explode_pulse.

Configuration
REQ-032 Macro BOMB_CHAIN_REACTION_EN defined: an ARMED slot j SHALL enter EXPLODING the cycle after any slot i asserts explode_pulse, if (x_j==x_i and |y_j-y_i|<=CHAIN_RANGE) or (y_j==y_i and |x_j-x_i|<=CHAIN_RANGE); chains propagate one hop per cycle.
REQ-033 Macro undefined: no slot-to-slot interaction; chain logic absent from netlist.

Verification
REQ-034 Reset, place_req at (100,200), 90 SOF pulses -> place_ack, place_slot=0, bomb_exist[0]=1; after 90th SOF bomb_exploded[0]=1, explode_pulse[0] one cycle; after 30 more SOF slot 0 IDLE at (1000,1000).
REQ-035 Five place_req with NUM_SLOTS=4 -> slots 0..3 acked, full=1, fifth gets place_nack, no state change.
REQ-036 Slot 1 ARMED, collision[1] and startOfFrame same cycle at counter 10 -> bomb_exploded[1]=1 next cycle, counter 0.
REQ-037 collision[2] while slot 2 IDLE and while EXPLODING -> no state or counter change.
REQ-038 With BOMB_CHAIN_REACTION_EN: bombs at (100,100), (140,100), (300,100); slot 0 collides -> slot 1 explodes one cycle later, slot 2 stays ARMED; without macro, slot 1 stays ARMED.
REQ-039 reset asserted mid-blast of slot 0, between clock edges -> all outputs cleared immediately, no explode_pulse after release.

Source files
------------

// File: rtl/bomb_slots_fsm.sv
// Bomb slot manager: per-slot IDLE -> ARMED -> EXPLODING -> IDLE timers driven by startOfFrame.
// Optional chain reactions between slots are enabled with `define BOMB_CHAIN_REACTION_EN.
module bomb_slots_fsm #(
  parameter int NUM_SLOTS    = 4,
  parameter int FUSE_FRAMES  = 90,
  parameter int BLAST_FRAMES = 30,
  parameter int OFF_X        = 1000,
  parameter int OFF_Y        = 1000,
  parameter int CHAIN_RANGE  = 64,
  localparam int SW          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          startOfFrame,
  input  logic                          place_req,
  input  logic signed [10:0]            place_x,
  input  logic signed [10:0]            place_y,
  input  logic [NUM_SLOTS-1:0]          collision,
  output logic                          place_ack,
  output logic                          place_nack,
  output logic [SW-1:0]                 place_slot,
  output logic [NUM_SLOTS-1:0]          bomb_exist,
  output logic [NUM_SLOTS-1:0]          bomb_exploded,
  output logic [NUM_SLOTS-1:0]          explode_pulse,
  output logic signed [11*NUM_SLOTS-1:0] topLeftX_out,
  output logic signed [11*NUM_SLOTS-1:0] topLeftY_out,
  output logic                          full
);

  localparam int CMAX = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_EXPL  = 2'd2;

  if (NUM_SLOTS < 1 || NUM_SLOTS > 16 || FUSE_FRAMES < 1 || BLAST_FRAMES < 1 || CHAIN_RANGE < 0)
  begin : g_bad_param
    $error("bomb_slots_fsm: parameter out of range");
  end

  logic [1:0]         state_q [NUM_SLOTS];
  logic [1:0]         state_d [NUM_SLOTS];
  logic [CW-1:0]      cnt_q   [NUM_SLOTS];
  logic [CW-1:0]      cnt_d   [NUM_SLOTS];
  logic signed [10:0] x_q     [NUM_SLOTS];
  logic signed [10:0] x_d     [NUM_SLOTS];
  logic signed [10:0] y_q     [NUM_SLOTS];
  logic signed [10:0] y_d     [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] chain_hit;
  logic               grant_vld;
  logic [SW-1:0]      grant_idx;
  logic               full_d;

`ifdef BOMB_CHAIN_REACTION_EN
  function automatic logic [11:0] dist(input logic signed [10:0] a, input logic signed [10:0] b);
    logic signed [11:0] d;
    d = {a[10], a} - {b[10], b};
    return (d < 0) ? 12'(-d) : 12'(d);
  endfunction

  // A slot exploding this cycle (explode_pulse) ignites armed neighbours on the same row/column.
  always_comb begin
    chain_hit = '0;
    for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (i != j && explode_pulse[i] && state_q[j] == S_ARMED) begin
          if ((x_q[j] == x_q[i] && dist(y_q[j], y_q[i]) <= 12'(CHAIN_RANGE)) ||
              (y_q[j] == y_q[i] && dist(x_q[j], x_q[i]) <= 12'(CHAIN_RANGE)))
            chain_hit[j] = 1'b1;
        end
      end
    end
  end
`else
  assign chain_hit = '0;
`endif

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!grant_vld && state_q[i] == S_IDLE) begin
        grant_vld = 1'b1;
        grant_idx = SW'(i);
      end
    end
    if (!place_req || full) grant_vld = 1'b0;
  end

  always_comb begin
    full_d = 1'b1;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (grant_vld && grant_idx == SW'(i)) begin
            state_d[i] = S_ARMED;
            cnt_d[i]   = '0;
            x_d[i]     = place_x;
            y_d[i]     = place_y;
          end
        end
        S_ARMED: begin
          if (collision[i] || chain_hit[i]) begin
            state_d[i] = S_EXPL;
            cnt_d[i]   = '0;
          end else if (startOfFrame) begin
            if (cnt_q[i] + CW'(1) == CW'(FUSE_FRAMES)) begin
              state_d[i] = S_EXPL;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
        S_EXPL: begin
          if (startOfFrame) begin
            if (cnt_q[i] + CW'(1) == CW'(BLAST_FRAMES)) begin
              state_d[i] = S_IDLE;
              cnt_d[i]   = '0;
              x_d[i]     = 11'(OFF_X);
              y_d[i]     = 11'(OFF_Y);
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
          x_d[i]     = 11'(OFF_X);
          y_d[i]     = 11'(OFF_Y);
        end
      endcase
      if (state_d[i] == S_IDLE) full_d = 1'b0;
    end
  end

  // Status outputs are registered from the next-state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        x_q[i]     <= 11'(OFF_X);
        y_q[i]     <= 11'(OFF_Y);
      end
      bomb_exist    <= '0;
      bomb_exploded <= '0;
      explode_pulse <= '0;
      full          <= 1'b0;
      place_ack     <= 1'b0;
      place_nack    <= 1'b0;
      place_slot    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        state_q[i]       <= state_d[i];
        cnt_q[i]         <= cnt_d[i];
        x_q[i]           <= x_d[i];
        y_q[i]           <= y_d[i];
        bomb_exist[i]    <= (state_d[i] == S_ARMED);
        bomb_exploded[i] <= (state_d[i] == S_EXPL);
        explode_pulse[i] <= (state_d[i] == S_EXPL) && (state_q[i] != S_EXPL);
      end
      full       <= full_d;
      place_ack  <= grant_vld;
      place_slot <= grant_vld ? grant_idx : '0;
      place_nack <= place_req && full;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      topLeftX_out[i*11 +: 11] = x_q[i];
      topLeftY_out[i*11 +: 11] = y_q[i];
    end
  end

endmodule

// File: tb/tb_bomb_slots_fsm.sv
// Directed bench for bomb_slots_fsm (default parameters); chain checks follow BOMB_CHAIN_REACTION_EN.
module tb_bomb_slots_fsm;
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               startOfFrame = 1'b0;
  logic               place_req = 1'b0;
  logic signed [10:0] place_x = '0;
  logic signed [10:0] place_y = '0;
  logic [3:0]         collision = '0;
  logic               place_ack, place_nack, full;
  logic [1:0]         place_slot;
  logic [3:0]         bomb_exist, bomb_exploded, explode_pulse;
  logic signed [43:0] topLeftX_out, topLeftY_out;

  int n_cmp = 0;
  int n_err = 0;

  bomb_slots_fsm #(.NUM_SLOTS(4), .FUSE_FRAMES(90), .BLAST_FRAMES(30),
                   .OFF_X(1000), .OFF_Y(1000), .CHAIN_RANGE(64)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .place_req(place_req),
    .place_x(place_x), .place_y(place_y), .collision(collision),
    .place_ack(place_ack), .place_nack(place_nack), .place_slot(place_slot),
    .bomb_exist(bomb_exist), .bomb_exploded(bomb_exploded), .explode_pulse(explode_pulse),
    .topLeftX_out(topLeftX_out), .topLeftY_out(topLeftY_out), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sof(input int n);
    for (int k = 0; k < n; k++) begin
      startOfFrame = 1'b1;
      cyc();
      startOfFrame = 1'b0;
      cyc();
    end
  endtask

  task automatic place(input int x, input int y);
    place_req = 1'b1;
    place_x   = 11'(x);
    place_y   = 11'(y);
    cyc();
    place_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  function automatic logic [31:0] posx(input int s);
    return 32'(topLeftX_out[s*11 +: 11]);
  endfunction

  function automatic logic [31:0] posy(input int s);
    return 32'(topLeftY_out[s*11 +: 11]);
  endfunction

  initial begin
    // Reset state
    cyc();
    cyc();
    chk("rst_exist", 32'(bomb_exist), 0);
    chk("rst_exploded", 32'(bomb_exploded), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_x0", posx(0), 1000);
    chk("rst_y3", posy(3), 1000);
    reset = 1'b0;
    cyc();

    // Single bomb full life cycle
    place(100, 200);
    chk("p0_ack", 32'(place_ack), 1);
    chk("p0_slot", 32'(place_slot), 0);
    chk("p0_exist", 32'(bomb_exist), 4'b0001);
    chk("p0_x", posx(0), 100);
    chk("p0_y", posy(0), 200);
    cyc();
    chk("p0_ack_drop", 32'(place_ack), 0);
    sof(89);
    chk("fuse89_exist", 32'(bomb_exist), 4'b0001);
    chk("fuse89_expl", 32'(bomb_exploded), 0);
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
    chk("fuse90_expl", 32'(bomb_exploded), 4'b0001);
    chk("fuse90_exist", 32'(bomb_exist), 0);
    chk("fuse90_pulse", 32'(explode_pulse), 4'b0001);
    cyc();
    chk("pulse_one_cycle", 32'(explode_pulse), 0);
    sof(29);
    chk("blast29_expl", 32'(bomb_exploded), 4'b0001);
    sof(1);
    chk("blast30_expl", 32'(bomb_exploded), 0);
    chk("blast30_exist", 32'(bomb_exist), 0);
    chk("blast30_x", posx(0), 1000);
    chk("blast30_y", posy(0), 1000);

    // Fill all slots, fifth request refused
    do_reset();
    for (int s = 0; s < 4; s++) begin
      place(10 * s, 20);
      chk($sformatf("fill_ack%0d", s), 32'(place_ack), 1);
      chk($sformatf("fill_slot%0d", s), 32'(place_slot), 32'(s));
    end
    chk("fill_full", 32'(full), 1);
    place(500, 500);
    chk("fifth_nack", 32'(place_nack), 1);
    chk("fifth_ack", 32'(place_ack), 0);
    chk("fifth_exist", 32'(bomb_exist), 4'b1111);
    chk("fifth_x3", posx(3), 30);
    cyc();
    chk("nack_drop", 32'(place_nack), 0);

    // Collision beats simultaneous SOF at counter 10
    sof(10);
    collision = 4'b0010;
    startOfFrame = 1'b1;
    cyc();
    collision = '0;
    startOfFrame = 1'b0;
    chk("coll_expl", 32'(bomb_exploded), 4'b0010);
    chk("coll_exist", 32'(bomb_exist), 4'b1101);
    chk("coll_pulse", 32'(explode_pulse), 4'b0010);
    chk("coll_full", 32'(full), 1);
    sof(29);
    chk("coll_cnt_cleared", 32'(bomb_exploded), 4'b0010);
    sof(1);
    chk("coll_done", 32'(bomb_exploded), 0);
    chk("freed_full", 32'(full), 0);
    place(77, 88);
    chk("realloc_ack", 32'(place_ack), 1);
    chk("realloc_slot", 32'(place_slot), 1);
    chk("realloc_x", posx(1), 77);

    // Collision ignored in IDLE and EXPLODING
    do_reset();
    place(0, 0);
    place(50, 0);
    collision = 4'b0100;
    cyc();
    collision = '0;
    chk("idle_coll_exist", 32'(bomb_exist), 4'b0011);
    chk("idle_coll_expl", 32'(bomb_exploded), 0);
    chk("idle_coll_pulse", 32'(explode_pulse), 0);
    place(400, 400);
    chk("s2_slot", 32'(place_slot), 2);
    collision = 4'b0100;
    cyc();
    collision = '0;
    chk("s2_expl", 32'(bomb_exploded), 4'b0100);
    sof(5);
    collision = 4'b0100;
    cyc();
    collision = '0;
    chk("expl_coll_pulse", 32'(explode_pulse), 0);
    sof(24);
    chk("expl_coll_cnt", 32'(bomb_exploded), 4'b0100);
    sof(1);
    chk("expl_coll_done", 32'(bomb_exploded), 0);
    chk("expl_coll_others", 32'(bomb_exist), 4'b0011);

    // Chain reaction
    do_reset();
    place(100, 100);
    place(140, 100);
    place(300, 100);
    collision = 4'b0001;
    cyc();
    collision = '0;
    chk("chain_src_pulse", 32'(explode_pulse), 4'b0001);
    cyc();
`ifdef BOMB_CHAIN_REACTION_EN
    chk("chain_hop_expl", 32'(bomb_exploded), 4'b0011);
    chk("chain_hop_pulse", 32'(explode_pulse), 4'b0010);
    chk("chain_hop_exist", 32'(bomb_exist), 4'b0100);
`else
    chk("chain_hop_expl", 32'(bomb_exploded), 4'b0001);
    chk("chain_hop_pulse", 32'(explode_pulse), 0);
    chk("chain_hop_exist", 32'(bomb_exist), 4'b0110);
`endif
    cyc();
    chk("chain_far_armed", 32'(bomb_exist[2]), 1);

    // Asynchronous reset mid-blast
    do_reset();
    place(100, 100);
    collision = 4'b0001;
    cyc();
    collision = '0;
    sof(5);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_expl", 32'(bomb_exploded), 0);
    chk("arst_exist", 32'(bomb_exist), 0);
    chk("arst_x0", posx(0), 1000);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      startOfFrame = 1'(k % 2);
      cyc();
      chk($sformatf("arst_pulse%0d", k), 32'(explode_pulse), 0);
      chk($sformatf("arst_expl%0d", k), 32'(bomb_exploded), 0);
    end
    startOfFrame = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
